sh_riscv_ifq_v1: RTL and testbench

SH_RISCV_IFQ_V1 -- requirements
Module: sh_riscv_ifq_v1

---
 rtl/sh_riscv_ifq_v1_pkg.sv | 13 +
 rtl/sh_sync_fifo.sv | 49 ++++
 rtl/sh_riscv_ifq_v1.sv | 124 ++++++++++++
 tb/tb_sh_riscv_ifq_v1.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sh_riscv_ifq_v1_pkg.sv
// Shared RISC-V fetch definitions: NOP encoding and the instruction-queue entry layout.
package sh_riscv_ifq_v1_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          ENTRY_W   = 65;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ifq_entry_t;

endpackage

// File: rtl/sh_sync_fifo.sv
// Synchronous FIFO with occupancy count and a synchronous flush that dominates push/pop.
module sh_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign pop_data = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sh_riscv_ifq_v1.sv
// Instruction fetch queue: issues in-order imem requests under a credit limit and
// buffers {pc, instr, fault} entries for decode, dropping responses made stale by a flush.
module sh_riscv_ifq_v1
    import sh_riscv_ifq_v1_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        fetch_stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        dec_fault
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits on ready. The imem response side has no ready and is taken in order.

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] outst;
    logic [CW-1:0] outst_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_count;
    logic [31:0]   tag_pc;
    logic [31:0]   last_pc;
    logic          misaligned;
    logic          credit;
    logic          fire;
    logic          mis_take;
    logic          rsp_take;
    logic          rsp_keep;
    logic          q_push;
    logic          dec_pop;
    ifq_entry_t    q_push_data;
    ifq_entry_t    q_head;

    assign misaligned = (pc_in[1:0] != 2'b00);
    assign credit     = ({1'b0, outst} + {1'b0, q_count}) < (CW + 1)'(DEPTH);

    assign imem_req_valid = reset_n & credit & !flush & !misaligned;
    assign imem_req_addr  = pc_in;
    assign fire           = imem_req_valid & imem_req_ready;

    // A misaligned PC is only consumed once nothing is in flight so queue order stays intact.
    assign mis_take    = reset_n & credit & (outst == '0) & !flush & misaligned;
    assign fetch_stall = !(fire | mis_take);

    assign rsp_take = imem_rsp_valid & (outst != '0);
    assign rsp_keep = rsp_take & (drop_cnt == '0);
    assign q_push   = rsp_keep | mis_take;
    assign dec_pop  = dec_valid & dec_ready;

    always_comb begin
        q_push_data = '{pc: tag_pc, instr: imem_rsp_data, fault: imem_rsp_err};
        if (mis_take) q_push_data = '{pc: pc_in, instr: NOP_INSTR, fault: 1'b1};
    end

    assign outst_next = outst + CW'(fire) - CW'(rsp_take);

    // The tag FIFO occupancy is exactly the number of outstanding requests.
    sh_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fire),
        .push_data (pc_in),
        .pop       (rsp_take),
        .flush     (1'b0),
        .pop_data  (tag_pc),
        .count     (outst)
    );

    sh_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (dec_pop),
        .flush     (flush),
        .pop_data  (q_head),
        .count     (q_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= outst_next;
        end else if (rsp_take && drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_pc <= RESET_PC;
        end else if (dec_pop && !flush) begin
            last_pc <= q_head.pc;
        end
    end

    assign dec_valid = (q_count != '0);
    assign dec_pc    = dec_valid ? q_head.pc    : last_pc;
    assign dec_instr = dec_valid ? q_head.instr : NOP_INSTR;
    assign dec_fault = dec_valid ? q_head.fault : 1'b0;

endmodule

// File: tb/tb_sh_riscv_ifq_v1.sv
// Directed bench for sh_riscv_ifq_v1: inputs change on the falling edge, outputs checked 1 ns later.
module tb_sh_riscv_ifq_v1;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_in;
    logic        flush;
    logic        fetch_stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sh_riscv_ifq_v1 #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc_in          (pc_in),
        .flush          (flush),
        .fetch_stall    (fetch_stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_fault      (dec_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset_n        = 1'b0;
        pc_in          = 32'h8000_0000;
        flush          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        dec_ready      = 1'b0;

        // reset state
        repeat (2) tick();
        #1;
        check("rst_dec_valid", dec_valid, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_stall", fetch_stall, 1);
        check("rst_dec_pc", dec_pc, RST_PC);
        check("rst_dec_instr", dec_instr, NOP);
        check("rst_dec_fault", dec_fault, 0);

        // single fetch, response one cycle after the request
        reset_n = 1'b1;
        #1;
        check("t1_req_valid", imem_req_valid, 1);
        check("t1_stall", fetch_stall, 0);
        check("t1_addr", imem_req_addr, 32'h8000_0000);
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00A0_0093;
        #1;
        check("t1_no_bypass", dec_valid, 0);
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        check("t1_dec_valid", dec_valid, 1);
        check("t1_dec_pc", dec_pc, 32'h8000_0000);
        check("t1_dec_instr", dec_instr, 32'h00A0_0093);
        check("t1_dec_fault", dec_fault, 0);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        #1;
        check("t1_empty", dec_valid, 0);
        check("t1_last_pc", dec_pc, 32'h8000_0000);
        check("t1_empty_instr", dec_instr, NOP);

        // memory not ready for 5 cycles
        pc_in = 32'h8000_0004;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t2_stall", fetch_stall, 1);
            check("t2_no_push", dec_valid, 0);
            tick();
        end

        // fill the credit window, then decode backpressure keeps the queue full
        dec_ready = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'h8000_0004 + 32'(4 * i);
            #1;
            check("t3_fire", fetch_stall, 0);
            tick();
        end
        pc_in = 32'h8000_0014;
        #1;
        check("t3_no_credit", imem_req_valid, 0);
        for (int i = 0; i < 4; i++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hA000_0000 + 32'(i);
            tick();
        end
        imem_rsp_valid = 1'b0;
        #1;
        check("t3_full_valid", dec_valid, 1);
        check("t3_full_req", imem_req_valid, 0);
        check("t3_full_stall", fetch_stall, 1);
        check("t3_head_pc", dec_pc, 32'h8000_0004);
        check("t3_head_instr", dec_instr, 32'hA000_0000);
        dec_ready = 1'b1;
        #1;
        check("t3_pop_not_credited", imem_req_valid, 0);
        tick();
        dec_ready = 1'b0;
        #1;
        check("t3_req_after_pop", imem_req_valid, 1);
        check("t3_stall_after_pop", fetch_stall, 0);
        check("t3_next_head", dec_pc, 32'h8000_0008);
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hA000_0004;
        dec_ready      = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_drain_pc", dec_pc, 32'h8000_000C + 32'(4 * i));
            check("t3_drain_instr", dec_instr, 32'hA000_0002 + 32'(i));
            tick();
        end
        dec_ready = 1'b0;
        #1;
        check("t3_drained", dec_valid, 0);

        // flush with two requests in flight
        imem_req_ready = 1'b1;
        pc_in = 32'h8000_0020;
        tick();
        pc_in = 32'h8000_0024;
        tick();
        flush = 1'b1;
        pc_in = 32'h8000_0100;
        #1;
        check("t4_flush_no_req", imem_req_valid, 0);
        check("t4_flush_stall", fetch_stall, 1);
        tick();
        flush = 1'b0;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0000;
        tick();
        #1;
        check("t4_stale1_dropped", dec_valid, 0);
        tick();
        imem_rsp_data = 32'h0000_0513;
        #1;
        check("t4_stale2_dropped", dec_valid, 0);
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        check("t4_new_valid", dec_valid, 1);
        check("t4_new_pc", dec_pc, 32'h8000_0100);
        check("t4_new_instr", dec_instr, 32'h0000_0513);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;

        // misaligned PC waits for the outstanding response to drain
        imem_req_ready = 1'b1;
        pc_in = 32'h8000_0200;
        tick();
        imem_req_ready = 1'b0;
        pc_in = 32'h8000_0202;
        #1;
        check("t5_mis_no_req", imem_req_valid, 0);
        check("t5_mis_wait", fetch_stall, 1);
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0613;
        #1;
        check("t5_mis_wait_rsp", fetch_stall, 1);
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        check("t5_mis_take", fetch_stall, 0);
        check("t5_mis_no_req2", imem_req_valid, 0);
        tick();
        pc_in = 32'h8000_0300;
        dec_ready = 1'b1;
        #1;
        check("t5_first_pc", dec_pc, 32'h8000_0200);
        check("t5_first_instr", dec_instr, 32'h0000_0613);
        check("t5_first_fault", dec_fault, 0);
        tick();
        #1;
        check("t5_mis_pc", dec_pc, 32'h8000_0202);
        check("t5_mis_instr", dec_instr, NOP);
        check("t5_mis_fault", dec_fault, 1);
        tick();
        dec_ready = 1'b0;
        #1;
        check("t5_empty", dec_valid, 0);

        // access fault, then reset in the middle of the burst
        imem_req_ready = 1'b1;
        pc_in = 32'h8000_0010;
        tick();
        pc_in = 32'h8000_0014;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        imem_rsp_data  = 32'h0;
        tick();
        imem_rsp_err  = 1'b0;
        imem_rsp_data = 32'h0000_0713;
        #1;
        check("t6_err_valid", dec_valid, 1);
        check("t6_err_fault", dec_fault, 1);
        check("t6_err_pc", dec_pc, 32'h8000_0010);
        reset_n = 1'b0;
        #1;
        check("t6_rst_dec_valid", dec_valid, 0);
        check("t6_rst_req_valid", imem_req_valid, 0);
        check("t6_rst_stall", fetch_stall, 1);
        check("t6_rst_dec_pc", dec_pc, RST_PC);
        tick();
        reset_n = 1'b1;
        imem_rsp_data = 32'h0000_0813;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        check("t6_late_rsp_ignored", dec_valid, 0);
        check("t6_late_dec_pc", dec_pc, RST_PC);
        check("t6_req_resumes", imem_req_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
